// File: rtl/eva_intr_pkg.sv
// rtl/eva_intr_pkg.sv - shared types and constants for the interrupt controller
//
// Purpose: per-channel trigger mode encoding, presenter FSM states and the
// all-ones pattern used to derive the drop-counter saturation value.
// Ports: none (package).
package eva_intr_pkg;

    typedef enum logic [1:0] {
        MODE_RISE  = 2'b00,
        MODE_FALL  = 2'b01,
        MODE_LEVEL = 2'b10,
        MODE_OFF   = 2'b11
    } mode_e;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PRESENT = 1'b1
    } state_e;

    // Widest supported drop counter; the controller slices this to CNT_W bits
    // to obtain its saturation value 2^CNT_W-1.
    localparam int                       OVF_CNT_MAX_W = 32;
    localparam logic [OVF_CNT_MAX_W-1:0] OVF_SAT_ONES  = '1;

endpackage

// File: rtl/eva_intr_arb.sv
// rtl/eva_intr_arb.sv - combinational channel arbiter, fixed or round-robin
//
// Purpose: picks one requesting channel. ARB_RR=1 searches upward from rr_ptr
// with wrap; ARB_RR=0 picks the lowest requesting index.
// Ports:
//   req    - masked pending requests, one bit per channel
//   rr_ptr - round-robin search start index
//   winner - selected channel index (0 when valid is low)
//   valid  - at least one request present
module eva_intr_arb #(
    parameter  int NUM_CH = 8,
    parameter  int ARB_RR = 1,
    localparam int IDX_W  = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [IDX_W-1:0]  rr_ptr,
    output logic [IDX_W-1:0]  winner,
    output logic              valid
);

    logic [IDX_W-1:0] idx;

    // (base + k) mod NUM_CH, valid for non-power-of-two channel counts too
    function automatic logic [IDX_W-1:0] rot_idx(input logic [IDX_W-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NUM_CH) s -= NUM_CH;
        return IDX_W'(s);
    endfunction

    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx    = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = (ARB_RR != 0) ? rot_idx(rr_ptr, k) : IDX_W'(k);
            if (!valid && req[idx]) begin
                valid  = 1'b1;
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/eva_intr_ctrl.sv
// rtl/eva_intr_ctrl.sv - interrupt controller with pending register and event presenter
//
// Purpose: detects per-channel edge/level events, latches them into a pending
// register, counts edge events lost to an already-pending channel, and presents
// one unmasked pending channel at a time over a valid/ready handshake.
// Ports:
//   clk, rst_n         - clock, synchronous active-low reset
//   intr_in            - raw interrupt lines
//   mode_cfg           - 2 bits per channel: rise / fall / level-high / disabled
//   mask               - 1 excludes a channel from arbitration (pend still sets)
//   evt_valid, evt_id  - presented event and its channel index
//   evt_ready          - consumer accepts the presented event
//   pend               - pending register
//   ovf_cnt, ovf_clr   - saturating dropped-edge counter and its clear
module eva_intr_ctrl
    import eva_intr_pkg::*;
#(
    parameter  int NUM_CH = 8,
    parameter  int CNT_W  = 8,
    parameter  int ARB_RR = 1,
    localparam int IDX_W  = $clog2(NUM_CH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_CH-1:0]   intr_in,
    input  logic [2*NUM_CH-1:0] mode_cfg,
    input  logic [NUM_CH-1:0]   mask,
    output logic                evt_valid,
    output logic [IDX_W-1:0]    evt_id,
    input  logic                evt_ready,
    output logic [NUM_CH-1:0]   pend,
    output logic [CNT_W-1:0]    ovf_cnt,
    input  logic                ovf_clr
);

    localparam logic [CNT_W-1:0] OVF_SAT = OVF_SAT_ONES[CNT_W-1:0];

    logic [NUM_CH-1:0] intr_ff;
    logic [NUM_CH-1:0] hit;
    logic [NUM_CH-1:0] edge_mode;
    logic [NUM_CH-1:0] off_mode;
    logic [NUM_CH-1:0] clr;
    logic [NUM_CH-1:0] drop;
    logic [NUM_CH-1:0] pend_nxt;
    logic [5:0]        drop_cnt;
    logic [CNT_W+5:0]  ovf_sum;
    logic [CNT_W-1:0]  ovf_nxt;
    logic              handshake;

    state_e            state;
    state_e            state_nxt;
    logic [IDX_W-1:0]  rr_ptr;
    logic [IDX_W-1:0]  rr_ptr_nxt;
    logic [IDX_W-1:0]  evt_id_nxt;
    logic [IDX_W-1:0]  win_id;
    logic              win_valid;

    always_comb begin
        hit       = '0;
        edge_mode = '0;
        off_mode  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            case (mode_e'(mode_cfg[2*i +: 2]))
                MODE_RISE: begin
                    hit[i]       = intr_in[i] & ~intr_ff[i];
                    edge_mode[i] = 1'b1;
                end
                MODE_FALL: begin
                    hit[i]       = ~intr_in[i] & intr_ff[i];
                    edge_mode[i] = 1'b1;
                end
                MODE_LEVEL: hit[i] = intr_in[i];
                default:    off_mode[i] = 1'b1;
            endcase
        end
    end

    assign handshake = (state == ST_PRESENT) && evt_ready;
    assign clr       = handshake ? (NUM_CH'(1) << evt_id) : '0;

    // A new event wins over the handshake clear; disabled channels stay clear.
    assign pend_nxt  = ~off_mode & (hit | (pend & ~clr));

    // Drop: edge event onto a channel already pending and not being cleared now.
    assign drop      = edge_mode & hit & pend & ~clr;

    always_comb begin
        drop_cnt = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            drop_cnt = drop_cnt + 6'(drop[i]);
        end
    end

    assign ovf_sum = {6'b0, ovf_cnt} + {{CNT_W{1'b0}}, drop_cnt};
    assign ovf_nxt = ovf_clr                  ? '0      :
                     (ovf_sum > {6'b0, OVF_SAT}) ? OVF_SAT :
                     ovf_sum[CNT_W-1:0];

    eva_intr_arb #(
        .NUM_CH (NUM_CH),
        .ARB_RR (ARB_RR)
    ) u_arb (
        .req    (pend & ~mask),
        .rr_ptr (rr_ptr),
        .winner (win_id),
        .valid  (win_valid)
    );

    // Presenter: evt_id is captured on entry to PRESENT and frozen until the
    // handshake, so mask/mode changes cannot alter an event already shown.
    always_comb begin
        state_nxt  = state;
        evt_id_nxt = evt_id;
        rr_ptr_nxt = rr_ptr;
        case (state)
            ST_IDLE: begin
                if (win_valid) begin
                    state_nxt  = ST_PRESENT;
                    evt_id_nxt = win_id;
                    rr_ptr_nxt = (win_id == IDX_W'(NUM_CH-1)) ? '0 : win_id + IDX_W'(1);
                end
            end
            ST_PRESENT: begin
                if (evt_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign evt_valid = (state == ST_PRESENT);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            evt_id  <= '0;
            rr_ptr  <= '0;
            intr_ff <= '0;
            pend    <= '0;
            ovf_cnt <= '0;
        end else begin
            state   <= state_nxt;
            evt_id  <= evt_id_nxt;
            rr_ptr  <= rr_ptr_nxt;
            intr_ff <= intr_in;
            pend    <= pend_nxt;
            ovf_cnt <= ovf_nxt;
        end
    end

endmodule

// File: tb/tb_eva_intr_ctrl.sv
// tb/tb_eva_intr_ctrl.sv - self-checking bench for eva_intr_ctrl
module tb_eva_intr_ctrl;

    localparam int N     = 8;
    localparam int CW_RR = 8;
    localparam int CW_FP = 3;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   intr_in;
    logic [2*N-1:0] mode_cfg;
    logic [N-1:0]   mask;
    logic           evt_ready;
    logic           ovf_clr;

    logic             v_rr, v_fp;
    logic [2:0]       id_rr, id_fp;
    logic [N-1:0]     pend_rr, pend_fp;
    logic [CW_RR-1:0] ovf_rr;
    logic [CW_FP-1:0] ovf_fp;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    eva_intr_ctrl #(.NUM_CH(N), .CNT_W(CW_RR), .ARB_RR(1)) dut_rr (
        .clk(clk), .rst_n(rst_n), .intr_in(intr_in), .mode_cfg(mode_cfg), .mask(mask),
        .evt_valid(v_rr), .evt_id(id_rr), .evt_ready(evt_ready), .pend(pend_rr),
        .ovf_cnt(ovf_rr), .ovf_clr(ovf_clr)
    );

    eva_intr_ctrl #(.NUM_CH(N), .CNT_W(CW_FP), .ARB_RR(0)) dut_fp (
        .clk(clk), .rst_n(rst_n), .intr_in(intr_in), .mode_cfg(mode_cfg), .mask(mask),
        .evt_valid(v_fp), .evt_id(id_fp), .evt_ready(evt_ready), .pend(pend_fp),
        .ovf_cnt(ovf_fp), .ovf_clr(ovf_clr)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // d=0 round-robin DUT, d=1 fixed-priority DUT; id only checked when valid expected
    task automatic chk_dut(input int d, input string tag, input int ev, input int eid,
                           input int epend, input int eovf);
        int av, aid, ap, ao;
        string nm;
        nm = (d == 0) ? "rr" : "fp";
        if (d == 0) begin av = v_rr; aid = id_rr; ap = pend_rr; ao = ovf_rr; end
        else        begin av = v_fp; aid = id_fp; ap = pend_fp; ao = ovf_fp; end
        chk($sformatf("%s/%s evt_valid", tag, nm), av, ev);
        if (ev != 0) chk($sformatf("%s/%s evt_id", tag, nm), aid, eid);
        if (epend >= 0) chk($sformatf("%s/%s pend", tag, nm), ap, epend);
        if (eovf >= 0) chk($sformatf("%s/%s ovf_cnt", tag, nm), ao, eovf);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    // ---------------- behavioural reference model ----------------
    bit [N-1:0] m_pend[2];
    bit [N-1:0] m_prev[2];
    int         m_cnt[2];
    int         m_id[2];
    int         m_ptr[2];
    bit         m_valid[2];

    task automatic model_step(input int d);
        int  cap, drops, md, nid, nptr;
        bit  hs, found, nvalid, h, cl;
        bit [N-1:0] np;
        cap = (d == 0) ? (1 << CW_RR) - 1 : (1 << CW_FP) - 1;
        if (!rst_n) begin
            m_pend[d] = '0; m_prev[d] = '0; m_cnt[d] = 0;
            m_valid[d] = 0; m_id[d] = 0; m_ptr[d] = 0;
            return;
        end
        hs     = m_valid[d] && evt_ready;
        nvalid = m_valid[d];
        nid    = m_id[d];
        nptr   = m_ptr[d];
        if (m_valid[d]) begin
            if (evt_ready) nvalid = 0;
        end else begin
            found = 0;
            for (int k = 0; k < N; k++) begin
                int ch;
                ch = (d == 0) ? (m_ptr[d] + k) % N : k;
                if (!found && m_pend[d][ch] && !mask[ch]) begin
                    found = 1; nvalid = 1; nid = ch; nptr = (ch + 1) % N;
                end
            end
        end
        drops = 0;
        np    = m_pend[d];
        for (int ch = 0; ch < N; ch++) begin
            md = mode_cfg[2*ch +: 2];
            case (md)
                0:       h = intr_in[ch] && !m_prev[d][ch];
                1:       h = !intr_in[ch] && m_prev[d][ch];
                2:       h = intr_in[ch];
                default: h = 0;
            endcase
            cl = hs && (m_id[d] == ch);
            if (md == 3) np[ch] = 0;
            else if (h) begin
                if (m_pend[d][ch] && !cl && md != 2) drops++;
                np[ch] = 1;
            end else if (cl) np[ch] = 0;
        end
        m_cnt[d]   = ovf_clr ? 0 : ((m_cnt[d] + drops > cap) ? cap : m_cnt[d] + drops);
        m_pend[d]  = np;
        m_prev[d]  = intr_in;
        m_valid[d] = nvalid;
        m_id[d]    = nid;
        m_ptr[d]   = nptr;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit         rst;
        logic [7:0] intr;
        logic [7:0] msk;
        bit         rdy;
        bit         clr;
        int         ev;
        int         eid;
        int         epend;
        int         eovf;
    } vec_t;

    vec_t tbl[22];

    logic [7:0] seq_in[9];
    int         rr_ids[9];
    int         fp_ids[9];

    initial begin
        rst_n = 1'b0; intr_in = '0; mode_cfg = '0; mask = '0; evt_ready = 1'b0; ovf_clr = 1'b0;

        //          rst intr   mask  rdy clr ev id pend   ovf
        tbl[0]  = '{0, 8'h00, 8'h00, 0, 0, 0, 0, 8'h00, 0};
        tbl[1]  = '{1, 8'h00, 8'h00, 0, 0, 0, 0, 8'h00, 0};
        tbl[2]  = '{1, 8'h08, 8'h00, 0, 0, 0, 0, 8'h08, 0};
        tbl[3]  = '{1, 8'h00, 8'h00, 0, 0, 1, 3, 8'h08, 0};
        tbl[4]  = '{1, 8'h00, 8'h00, 1, 0, 0, 0, 8'h00, 0};
        tbl[5]  = '{1, 8'h04, 8'h00, 0, 0, 0, 0, 8'h04, 0};
        tbl[6]  = '{1, 8'h00, 8'h00, 0, 0, 1, 2, 8'h04, 0};
        tbl[7]  = '{1, 8'h04, 8'h00, 0, 0, 1, 2, 8'h04, 1};
        tbl[8]  = '{1, 8'h00, 8'h00, 0, 0, 1, 2, 8'h04, 1};
        tbl[9]  = '{1, 8'h04, 8'h00, 0, 0, 1, 2, 8'h04, 2};
        tbl[10] = '{1, 8'h00, 8'h00, 0, 0, 1, 2, 8'h04, 2};
        tbl[11] = '{1, 8'h04, 8'h00, 0, 1, 1, 2, 8'h04, 0};
        tbl[12] = '{1, 8'h00, 8'h00, 1, 0, 0, 0, 8'h00, 0};
        tbl[13] = '{1, 8'h04, 8'h00, 1, 0, 0, 0, 8'h04, 0};
        tbl[14] = '{1, 8'h00, 8'h00, 1, 0, 1, 2, 8'h04, 0};
        tbl[15] = '{1, 8'h04, 8'h00, 1, 0, 0, 0, 8'h04, 0};
        tbl[16] = '{1, 8'h00, 8'h00, 0, 0, 1, 2, 8'h04, 0};
        tbl[17] = '{1, 8'h00, 8'h00, 1, 0, 0, 0, 8'h00, 0};
        tbl[18] = '{1, 8'h02, 8'h02, 0, 0, 0, 0, 8'h02, 0};
        tbl[19] = '{1, 8'h00, 8'h02, 0, 0, 0, 0, 8'h02, 0};
        tbl[20] = '{1, 8'h00, 8'h00, 0, 0, 1, 1, 8'h02, 0};
        tbl[21] = '{1, 8'h00, 8'h00, 1, 0, 0, 0, 8'h00, 0};

        for (int i = 0; i < 22; i++) begin
            rst_n = tbl[i].rst; intr_in = tbl[i].intr; mask = tbl[i].msk;
            evt_ready = tbl[i].rdy; ovf_clr = tbl[i].clr;
            tick();
            for (int d = 0; d < 2; d++)
                chk_dut(d, $sformatf("tbl%0d", i), tbl[i].ev, tbl[i].eid, tbl[i].epend, tbl[i].eovf);
        end
        ovf_clr = 1'b0; evt_ready = 1'b0; mask = '0; intr_in = '0;

        // ---- three channels rise together; ch1 re-raised during ch5's turn ----
        do_reset();
        evt_ready = 1'b1;
        seq_in = '{8'h62, 8'h60, 8'h60, 8'h62, 8'h62, 8'h62, 8'h62, 8'h62, 8'h62};
        rr_ids = '{0, 1, 0, 5, 0, 6, 0, 1, 0};
        fp_ids = '{0, 1, 0, 5, 0, 1, 0, 6, 0};
        for (int s = 0; s < 9; s++) begin
            intr_in = seq_in[s];
            tick();
            chk_dut(0, $sformatf("arb%0d", s), s % 2, rr_ids[s], (s == 8) ? 0 : -1, 0);
            chk_dut(1, $sformatf("arb%0d", s), s % 2, fp_ids[s], (s == 8) ? 0 : -1, 0);
        end

        // ---- level-mode channel 0 held high, then masked mid-presentation ----
        rst_n = 1'b0; intr_in = 8'h01; mode_cfg = 16'hFFFE; mask = '0; evt_ready = 1'b1;
        tick();
        rst_n = 1'b1;
        for (int s = 0; s < 6; s++) begin
            tick();
            for (int d = 0; d < 2; d++) chk_dut(d, $sformatf("lvl%0d", s), s % 2, 0, 8'h01, 0);
        end
        mask = 8'h01;
        for (int s = 0; s < 5; s++) begin
            tick();
            for (int d = 0; d < 2; d++) chk_dut(d, $sformatf("lvlmask%0d", s), 0, 0, 8'h01, 0);
        end

        // ---- reset while presenting channel 4; line still high at release ----
        mask = '0; mode_cfg = '0; intr_in = '0; evt_ready = 1'b0;
        do_reset();
        intr_in = 8'h10; tick();
        for (int d = 0; d < 2; d++) chk_dut(d, "rst_a", 0, 0, 8'h10, 0);
        tick();
        for (int d = 0; d < 2; d++) chk_dut(d, "rst_b", 1, 4, 8'h10, 0);
        intr_in = 8'h00; tick();
        intr_in = 8'h10; tick();
        for (int d = 0; d < 2; d++) chk_dut(d, "rst_c", 1, 4, 8'h10, 1);
        rst_n = 1'b0; tick();
        for (int d = 0; d < 2; d++) chk_dut(d, "rst_d", 0, 0, 8'h00, 0);
        rst_n = 1'b1; tick();
        for (int d = 0; d < 2; d++) chk_dut(d, "rst_e", 0, 0, 8'h10, 0);
        tick();
        for (int d = 0; d < 2; d++) chk_dut(d, "rst_f", 1, 4, 8'h10, 0);
        evt_ready = 1'b1; tick();
        for (int d = 0; d < 2; d++) chk_dut(d, "rst_g", 0, 0, 8'h00, 0);

        // ---- randomized run against the reference model ----
        intr_in = '0; mask = '0; mode_cfg = 16'($urandom); evt_ready = 1'b0; ovf_clr = 1'b0;
        rst_n = 1'b0;
        model_step(0); model_step(1);
        tick();
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 49) == 0) mode_cfg = 16'($urandom);
            if ($urandom_range(0, 19) == 0) mask = 8'($urandom) & 8'($urandom);
            intr_in   = intr_in ^ (8'($urandom) & 8'($urandom));
            evt_ready = ($urandom_range(0, 2) == 0);
            ovf_clr   = ($urandom_range(0, 59) == 0);
            rst_n     = ($urandom_range(0, 399) != 0);
            model_step(0); model_step(1);
            tick();
            for (int d = 0; d < 2; d++)
                chk_dut(d, $sformatf("rand%0d", c), m_valid[d], m_id[d], m_pend[d], m_cnt[d]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
